// File: rtl/ahb_protocol_monitor_pkg.sv
// Shared AHB-Lite encodings, error-bit indices and burst helpers for the protocol monitor.
package ahb_mon_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    localparam int ERR_W       = 6;
    localparam int ERR_SEQ     = 0;
    localparam int ERR_ADDR    = 1;
    localparam int ERR_CTRL    = 2;
    localparam int ERR_LEN     = 3;
    localparam int ERR_TIMEOUT = 4;
    localparam int ERR_SIZE    = 5;

    // Beats in a burst; 0 means undefined length (INCR).
    function automatic logic [4:0] burst_len(input logic [2:0] hburst);
        logic [4:0] len;
        case (hburst_e'(hburst))
            HBURST_SINGLE:                len = 5'd1;
            HBURST_INCR:                  len = 5'd0;
            HBURST_WRAP4,  HBURST_INCR4:  len = 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  len = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: len = 5'd16;
            default:                      len = 5'd0;
        endcase
        return len;
    endfunction

    function automatic logic is_wrap(input logic [2:0] hburst);
        return (hburst[0] == 1'b0) && (hburst[2:1] != 2'b00);
    endfunction

endpackage

// File: rtl/ahb_protocol_monitor_if.sv
// AHB-Lite address/control bundle shared by master, slave and the passive monitor.
interface ahb_protocol_monitor_if #(
    parameter int ADDR_W = 32
);
    logic [1:0]        htrans;
    logic [2:0]        hburst;
    logic [2:0]        hsize;
    logic              hwrite;
    logic [ADDR_W-1:0] haddr;
    logic              hready;

    modport master  (output htrans, hburst, hsize, hwrite, haddr, input hready);
    modport slave   (input htrans, hburst, hsize, hwrite, haddr, output hready);
    modport monitor (input htrans, hburst, hsize, hwrite, haddr, hready);
endinterface

// File: rtl/ahb_protocol_monitor_addr_calc.sv
// Combinational next-beat address generator for INCR and WRAP bursts.
module ahb_addr_calc
    import ahb_mon_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [2:0]        hsize_i,
    input  logic [2:0]        hburst_i,
    output logic [ADDR_W-1:0] next_addr_o
);

    logic [ADDR_W-1:0] inc;
    logic [ADDR_W-1:0] sum;
    logic [ADDR_W-1:0] wrap_mask;
    logic [2:0]        wrap_shift;

    // WRAP4/8/16 encode log2(beats)-1 in hburst[2:1].
    assign wrap_shift  = {1'b0, hburst_i[2:1]} + 3'd1;
    assign inc         = ADDR_W'(1) << hsize_i;
    assign sum         = addr_i + inc;
    assign wrap_mask   = (inc << wrap_shift) - ADDR_W'(1);
    assign next_addr_o = is_wrap(hburst_i) ? ((addr_i & ~wrap_mask) | (sum & wrap_mask)) : sum;

endmodule

// File: rtl/ahb_protocol_monitor.sv
// Passive AHB-Lite protocol monitor: burst tracking, address/control checks, stall timeout.
// Optional burst statistics outputs are built when AHB_MON_STATS_EN is defined.
module ahb_protocol_monitor
    import ahb_mon_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 8
) (
    input  logic                  hclk,
    input  logic                  hreset,
    ahb_protocol_monitor_if.monitor bus,
    input  logic                  err_clr,
    output logic [ERR_W-1:0]      err_flags,
    output logic                  err_pulse,
    output logic [CNT_W-1:0]      err_count,
    output logic                  in_burst,
    output logic [4:0]            beat_cnt
`ifdef AHB_MON_STATS_EN
    ,
    output logic [CNT_W-1:0]      wr_bursts,
    output logic [CNT_W-1:0]      rd_bursts
`endif
);

    localparam logic [2:0]      MAX_SIZE = 3'($clog2(DATA_W / 8));
    localparam int              TO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC);
    localparam logic [0:0]      ST_IDLE  = 1'b0;
    localparam logic [0:0]      ST_BURST = 1'b1;

    logic [1:0]        htrans;
    logic [2:0]        hburst;
    logic [2:0]        hsize;
    logic              hwrite;
    logic [ADDR_W-1:0] haddr;
    logic              hready;

    assign htrans = bus.htrans;
    assign hburst = bus.hburst;
    assign hsize  = bus.hsize;
    assign hwrite = bus.hwrite;
    assign haddr  = bus.haddr;
    assign hready = bus.hready;

    logic [0:0]        state_q, state_d;
    logic [4:0]        beat_q, beat_d;
    logic [4:0]        len_q, len_d;
    logic [2:0]        hburst_q, hburst_d;
    logic [2:0]        hsize_q, hsize_d;
    logic              hwrite_q, hwrite_d;
    logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;
    logic              done_q, done_d;
    logic              burst_err_q, burst_err_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [ERR_W-1:0]  flags_q, flags_d;
    logic              pulse_q;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [ERR_W-1:0]  viol;
    logic              start;
    logic              cmpl_old;
    logic              cmpl_new;
    logic              beat_err;
    logic              accept;
    logic              size_err;
    logic              new_burst;
    logic [ADDR_W-1:0] align_mask;
    logic [ADDR_W-1:0] calc_addr;
    logic [2:0]        calc_size;
    logic [2:0]        calc_burst;
    logic [ADDR_W-1:0] next_addr;

    assign accept     = hready & htrans[1];
    assign align_mask = (ADDR_W'(1) << hsize) - ADDR_W'(1);
    assign size_err   = accept & ((hsize > MAX_SIZE) | (|(haddr & align_mask)));

    // A NONSEQ seeds the generator from the bus; a SEQ advances from the tracked address.
    assign new_burst  = (htrans == HTRANS_NONSEQ);
    assign calc_addr  = new_burst ? haddr  : exp_addr_q;
    assign calc_size  = new_burst ? hsize  : hsize_q;
    assign calc_burst = new_burst ? hburst : hburst_q;

    ahb_addr_calc #(
        .ADDR_W (ADDR_W)
    ) u_addr_calc (
        .addr_i      (calc_addr),
        .hsize_i     (calc_size),
        .hburst_i    (calc_burst),
        .next_addr_o (next_addr)
    );

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        len_d       = len_q;
        hburst_d    = hburst_q;
        hsize_d     = hsize_q;
        hwrite_d    = hwrite_q;
        exp_addr_d  = exp_addr_q;
        done_d      = done_q;
        burst_err_d = burst_err_q;
        to_cnt_d    = to_cnt_q;
        viol        = '0;
        start       = 1'b0;
        cmpl_old    = 1'b0;
        cmpl_new    = 1'b0;
        beat_err    = 1'b0;

        if (!hready) begin
            // Counter parks at the limit so a long stall flags only once.
            if (to_cnt_q != TO_LIMIT) begin
                to_cnt_d          = to_cnt_q + TO_W'(1);
                viol[ERR_TIMEOUT] = (to_cnt_q == TO_LIMIT - TO_W'(1));
            end
        end else begin
            to_cnt_d       = '0;
            viol[ERR_SIZE] = size_err;
            if (state_q == ST_IDLE) begin
                if (htrans == HTRANS_NONSEQ) begin
                    start = 1'b1;
                end else if (htrans != HTRANS_IDLE) begin
                    viol[ERR_SEQ] = 1'b1;
                    viol[ERR_LEN] = done_q & (htrans == HTRANS_SEQ);
                end
                if (!htrans[0]) begin
                    done_d = 1'b0;
                end
            end else begin
                case (htrans)
                    HTRANS_SEQ: begin
                        viol[ERR_ADDR] = (haddr != exp_addr_q);
                        viol[ERR_CTRL] = (hsize != hsize_q) | (hburst != hburst_q) | (hwrite != hwrite_q);
                        beat_err       = viol[ERR_ADDR] | viol[ERR_CTRL] | size_err;
                        burst_err_d    = burst_err_q | beat_err;
                        exp_addr_d     = next_addr;
                        beat_d         = (beat_q == 5'h1F) ? beat_q : beat_q + 5'd1;
                        if ((len_q != 5'd0) && (beat_q + 5'd1 == len_q)) begin
                            state_d  = ST_IDLE;
                            done_d   = 1'b1;
                            cmpl_old = ~(burst_err_q | beat_err);
                        end
                    end
                    HTRANS_NONSEQ, HTRANS_IDLE: begin
                        viol[ERR_LEN] = (len_q != 5'd0);
                        cmpl_old      = (len_q == 5'd0) & ~burst_err_q;
                        state_d       = ST_IDLE;
                        start         = (htrans == HTRANS_NONSEQ);
                    end
                    default: ;
                endcase
            end

            if (start) begin
                hburst_d    = hburst;
                hsize_d     = hsize;
                hwrite_d    = hwrite;
                len_d       = burst_len(hburst);
                beat_d      = 5'd1;
                exp_addr_d  = next_addr;
                burst_err_d = size_err;
                done_d      = 1'b0;
                if (burst_len(hburst) == 5'd1) begin
                    state_d  = ST_IDLE;
                    cmpl_new = ~size_err;
                end else begin
                    state_d  = ST_BURST;
                end
            end
        end
    end

    // err_clr wins over history but never masks a violation detected in the same cycle.
    always_comb begin
        flags_d = err_clr ? viol : (flags_q | viol);
        count_d = count_q;
        if (err_clr) begin
            count_d = (|viol) ? CNT_W'(1) : '0;
        end else if ((|viol) && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            len_q       <= '0;
            hburst_q    <= '0;
            hsize_q     <= '0;
            hwrite_q    <= 1'b0;
            exp_addr_q  <= '0;
            done_q      <= 1'b0;
            burst_err_q <= 1'b0;
            to_cnt_q    <= '0;
            flags_q     <= '0;
            pulse_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            len_q       <= len_d;
            hburst_q    <= hburst_d;
            hsize_q     <= hsize_d;
            hwrite_q    <= hwrite_d;
            exp_addr_q  <= exp_addr_d;
            done_q      <= done_d;
            burst_err_q <= burst_err_d;
            to_cnt_q    <= to_cnt_d;
            flags_q     <= flags_d;
            pulse_q     <= |viol;
            count_q     <= count_d;
        end
    end

    assign err_flags = flags_q;
    assign err_pulse = pulse_q;
    assign err_count = count_q;
    assign in_burst  = (state_q == ST_BURST);
    assign beat_cnt  = beat_q;

`ifdef AHB_MON_STATS_EN
    logic [CNT_W-1:0] wr_bursts_q;
    logic [CNT_W-1:0] rd_bursts_q;
    logic [1:0]       wr_add;
    logic [1:0]       rd_add;

    // One burst can end and a clean SINGLE can complete on the same NONSEQ.
    assign wr_add = {1'b0, cmpl_old & hwrite_q}  + {1'b0, cmpl_new & hwrite};
    assign rd_add = {1'b0, cmpl_old & ~hwrite_q} + {1'b0, cmpl_new & ~hwrite};

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] val, input logic [1:0] n);
        logic [CNT_W:0] s;
        s = {1'b0, val} + (CNT_W + 1)'(n);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            wr_bursts_q <= '0;
            rd_bursts_q <= '0;
        end else if (err_clr) begin
            wr_bursts_q <= '0;
            rd_bursts_q <= '0;
        end else begin
            wr_bursts_q <= sat_add(wr_bursts_q, wr_add);
            rd_bursts_q <= sat_add(rd_bursts_q, rd_add);
        end
    end

    assign wr_bursts = wr_bursts_q;
    assign rd_bursts = rd_bursts_q;
`else
    logic unused_stats;
    assign unused_stats = ^{cmpl_old, cmpl_new};
`endif

endmodule

// File: tb/tb_ahb_protocol_monitor.sv
// Directed bench for ahb_protocol_monitor: expected outputs are queued with each driven beat and checked after the edge.
`timescale 1ns/1ps
module tb_ahb_protocol_monitor;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int TIMEOUT_CYC = 16;
    localparam int CNT_W       = 8;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NS   = 2'b10;
    localparam logic [1:0] T_SQ   = 2'b11;
    localparam logic [2:0] B_SINGLE = 3'b000;
    localparam logic [2:0] B_INCR   = 3'b001;
    localparam logic [2:0] B_WRAP4  = 3'b010;
    localparam logic [2:0] B_INCR4  = 3'b011;
    localparam logic [2:0] B_INCR8  = 3'b101;
    localparam logic [2:0] B_INCR16 = 3'b111;
    localparam logic [2:0] S_H = 3'b001;
    localparam logic [2:0] S_W = 3'b010;
    localparam logic [2:0] S_D = 3'b011;

    logic             hclk    = 1'b0;
    logic             hreset  = 1'b1;
    logic             err_clr = 1'b0;
    logic [5:0]       err_flags;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
    logic             in_burst;
    logic [4:0]       beat_cnt;
`ifdef AHB_MON_STATS_EN
    logic [CNT_W-1:0] wr_bursts;
    logic [CNT_W-1:0] rd_bursts;
`endif

    ahb_protocol_monitor_if #(.ADDR_W(ADDR_W)) mon_if ();

    ahb_protocol_monitor #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .bus       (mon_if),
        .err_clr   (err_clr),
        .err_flags (err_flags),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .in_burst  (in_burst),
        .beat_cnt  (beat_cnt)
`ifdef AHB_MON_STATS_EN
        ,
        .wr_bursts (wr_bursts),
        .rd_bursts (rd_bursts)
`endif
    );

    always #5 hclk = ~hclk;

    typedef struct packed {
        logic [5:0] flags;
        logic       pulse;
        logic [7:0] count;
        logic       inb;
        logic [4:0] beat;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    n_assert = 0;
    int    n_fail   = 0;

    task automatic drive(input logic [1:0] tr, input logic [2:0] bu, input logic [2:0] sz,
                         input logic wr, input logic [31:0] ad, input logic rdy, input logic clr);
        mon_if.htrans = tr;
        mon_if.hburst = bu;
        mon_if.hsize  = sz;
        mon_if.hwrite = wr;
        mon_if.haddr  = ad;
        mon_if.hready = rdy;
        err_clr       = clr;
    endtask

    task automatic expect_out(input string tag, input logic [5:0] fl, input logic pu,
                              input logic [7:0] cnt, input logic ib, input logic [4:0] bc);
        exp_t e;
        e.flags = fl;
        e.pulse = pu;
        e.count = cnt;
        e.inb   = ib;
        e.beat  = bc;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_field(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] ex);
        if (!$isunknown(ex)) begin
            n_assert++;
            assert (obs === ex) else begin
                n_fail++;
                $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, ex);
            end
        end
    endtask

    task automatic check_pop();
        exp_t  e;
        string t;
        if (sb_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL scoreboard_empty observed=none expected=entry");
        end else begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            check_field(t, "err_flags", 32'(err_flags), 32'(e.flags));
            check_field(t, "err_pulse", 32'(err_pulse), 32'(e.pulse));
            check_field(t, "err_count", 32'(err_count), 32'(e.count));
            check_field(t, "in_burst",  32'(in_burst),  32'(e.inb));
            check_field(t, "beat_cnt",  32'(beat_cnt),  {27'b0, e.beat});
        end
    endtask

    task automatic step(input string tag, input logic [1:0] tr, input logic [2:0] bu, input logic [2:0] sz,
                        input logic wr, input logic [31:0] ad, input logic rdy, input logic clr,
                        input logic [5:0] fl, input logic pu, input logic [7:0] cnt,
                        input logic ib, input logic [4:0] bc);
        drive(tr, bu, sz, wr, ad, rdy, clr);
        expect_out(tag, fl, pu, cnt, ib, bc);
        @(posedge hclk);
        #1;
        check_pop();
    endtask

    initial begin
        drive(T_IDLE, B_SINGLE, S_W, 1'b1, 32'h0, 1'b1, 1'b0);
        step("reset0", T_IDLE, B_SINGLE, S_W, 1, 32'h0, 1, 0, 6'h00, 0, 8'd0, 0, 5'd0);
        step("reset1", T_IDLE, B_SINGLE, S_W, 1, 32'h0, 1, 0, 6'h00, 0, 8'd0, 0, 5'd0);
        hreset = 1'b0;

        // INCR4 word burst with one stall cycle
        step("incr4_b1",    T_NS,   B_INCR4, S_W, 1, 32'h100, 1, 0, 6'h00, 0, 8'd0, 1, 5'd1);
        step("incr4_b2",    T_SQ,   B_INCR4, S_W, 1, 32'h104, 1, 0, 6'h00, 0, 8'd0, 1, 5'd2);
        step("incr4_stall", T_SQ,   B_INCR4, S_W, 1, 32'h108, 0, 0, 6'h00, 0, 8'd0, 1, 5'd2);
        step("incr4_b3",    T_SQ,   B_INCR4, S_W, 1, 32'h108, 1, 0, 6'h00, 0, 8'd0, 1, 5'd3);
        step("incr4_b4",    T_SQ,   B_INCR4, S_W, 1, 32'h10C, 1, 0, 6'h00, 0, 8'd0, 0, 5'd4);
        step("incr4_idle",  T_IDLE, B_INCR4, S_W, 1, 32'h0,   1, 0, 6'h00, 0, 8'd0, 0, 5'd4);

        // WRAP4 from 0x38 with a wrong third beat
        step("wrap4_b1",   T_NS,   B_WRAP4, S_W, 1, 32'h38, 1, 0, 6'h00, 0, 8'd0, 1, 5'd1);
        step("wrap4_b2",   T_SQ,   B_WRAP4, S_W, 1, 32'h3C, 1, 0, 6'h00, 0, 8'd0, 1, 5'd2);
        step("wrap4_busy", T_BUSY, B_WRAP4, S_W, 1, 32'h40, 1, 0, 6'h00, 0, 8'd0, 1, 5'd2);
        step("wrap4_bad",  T_SQ,   B_WRAP4, S_W, 1, 32'h40, 1, 0, 6'h02, 1, 8'd1, 1, 5'd3);
        step("wrap4_b4",   T_SQ,   B_WRAP4, S_W, 1, 32'h34, 1, 0, 6'h02, 0, 8'd1, 0, 5'd4);
        step("wrap4_idle", T_IDLE, B_WRAP4, S_W, 1, 32'h0,  1, 0, 6'h02, 0, 8'd1, 0, 5'd4);

        // SEQ straight after reset, then err_clr coinciding with a truncated INCR8
        hreset = 1'b1;
        step("rst_pulse", T_IDLE, B_SINGLE, S_W, 1, 32'h0, 1, 0, 6'h00, 0, 8'd0, 0, 5'd0);
        hreset = 1'b0;
        step("seq_idle",   T_SQ,   B_INCR,   S_W, 1, 32'h0,   1, 0, 6'h01, 1, 8'd1, 0, 5'd0);
        step("seq_idle2",  T_IDLE, B_INCR,   S_W, 1, 32'h0,   1, 0, 6'h01, 0, 8'd1, 0, 5'd0);
        step("incr8_b1",   T_NS,   B_INCR8,  S_W, 1, 32'h200, 1, 0, 6'h01, 0, 8'd1, 1, 5'd1);
        step("incr8_b2",   T_SQ,   B_INCR8,  S_W, 1, 32'h204, 1, 0, 6'h01, 0, 8'd1, 1, 5'd2);
        step("incr8_b3",   T_SQ,   B_INCR8,  S_W, 1, 32'h208, 1, 0, 6'h01, 0, 8'd1, 1, 5'd3);
        step("incr8_cut",  T_NS,   B_SINGLE, S_W, 1, 32'h300, 1, 1, 6'h08, 1, 8'd1, 0, 5'd1);
        step("incr8_idle", T_IDLE, B_SINGLE, S_W, 1, 32'h0,   1, 0, 6'h08, 0, 8'd1, 0, 5'd1);

        // Timeout: 15 low cycles are fine, 16 flag exactly once
        step("to_clr", T_IDLE, B_SINGLE, S_W, 1, 32'h0, 1, 1, 6'h00, 0, 8'd0, 0, 5'd1);
        for (int i = 1; i <= 15; i++)
            step($sformatf("to15_%0d", i), T_IDLE, B_SINGLE, S_W, 1, 32'h0, 0, 0, 6'h00, 0, 8'd0, 0, 5'd1);
        step("to15_rel", T_IDLE, B_SINGLE, S_W, 1, 32'h0, 1, 0, 6'h00, 0, 8'd0, 0, 5'd1);
        for (int i = 1; i <= 16; i++)
            step($sformatf("to16_%0d", i), T_IDLE, B_SINGLE, S_W, 1, 32'h0, 0, 0,
                 (i == 16) ? 6'h10 : 6'h00, (i == 16), (i == 16) ? 8'd1 : 8'd0, 0, 5'd1);
        for (int i = 1; i <= 3; i++)
            step($sformatf("to_hold_%0d", i), T_IDLE, B_SINGLE, S_W, 1, 32'h0, 0, 0, 6'h10, 0, 8'd1, 0, 5'd1);
        step("to_rel", T_IDLE, B_SINGLE, S_W, 1, 32'h0, 1, 0, 6'h10, 0, 8'd1, 0, 5'd1);

        // Size and alignment
        step("sz_clr",    T_IDLE, B_SINGLE, S_W, 1, 32'h0,   1, 1, 6'h00, 0, 8'd0, 0, 5'd1);
        step("sz_dword",  T_NS,   B_SINGLE, S_D, 1, 32'h0,   1, 0, 6'h20, 1, 8'd1, 0, 5'd1);
        step("sz_idle",   T_IDLE, B_SINGLE, S_W, 1, 32'h0,   1, 0, 6'h20, 0, 8'd1, 0, 5'd1);
        step("sz_mis",    T_NS,   B_SINGLE, S_H, 1, 32'h101, 1, 0, 6'h20, 1, 8'd2, 0, 5'd1);
        step("sz_ok",     T_NS,   B_SINGLE, S_H, 1, 32'h102, 1, 0, 6'h20, 0, 8'd2, 0, 5'd1);
        step("sz_idle2",  T_IDLE, B_SINGLE, S_W, 1, 32'h0,   1, 0, 6'h20, 0, 8'd2, 0, 5'd1);

        // Counter saturation over 300 violating cycles
        step("sat_clr", T_IDLE, B_SINGLE, S_W, 1, 32'h0, 1, 1, 6'h00, 0, 8'd0, 0, 5'd1);
        for (int i = 1; i <= 300; i++)
            step($sformatf("sat_%0d", i), T_SQ, B_INCR, S_W, 1, 32'h0, 1, 0, 6'h01, 1,
                 (i > 255) ? 8'd255 : 8'(i), 0, 5'd1);
        step("sat_idle", T_IDLE, B_SINGLE, S_W, 1, 32'h0, 1, 0, 6'h01, 0, 8'd255, 0, 5'd1);
        step("sat_clr2", T_IDLE, B_SINGLE, S_W, 1, 32'h0, 1, 1, 6'h00, 0, 8'd0,   0, 5'd1);

        // Asynchronous reset in the middle of an INCR16
        step("i16_b1", T_NS, B_INCR16, S_W, 1, 32'h400, 1, 0, 6'h00, 0, 8'd0, 1, 5'd1);
        step("i16_b2", T_SQ, B_INCR16, S_W, 1, 32'h404, 1, 0, 6'h00, 0, 8'd0, 1, 5'd2);
        step("i16_b3", T_SQ, B_INCR16, S_W, 1, 32'h408, 1, 0, 6'h00, 0, 8'd0, 1, 5'd3);
        step("i16_b4", T_SQ, B_INCR16, S_W, 1, 32'h40C, 1, 0, 6'h00, 0, 8'd0, 1, 5'd4);
        step("i16_b5", T_SQ, B_INCR16, S_W, 1, 32'h410, 1, 0, 6'h00, 0, 8'd0, 1, 5'd5);
        hreset = 1'b1;
        #1;
        expect_out("i16_async_rst", 6'h00, 0, 8'd0, 0, 5'd0);
        check_pop();
        step("i16_rst_hold", T_IDLE, B_SINGLE, S_W, 1, 32'h0, 1, 0, 6'h00, 0, 8'd0, 0, 5'd0);
        hreset = 1'b0;
        step("post_b1",  T_NS, B_INCR4, S_W, 1, 32'h500, 1, 0, 6'h00, 0, 8'd0, 1, 5'd1);
        step("post_b2",  T_SQ, B_INCR4, S_W, 1, 32'h504, 1, 0, 6'h00, 0, 8'd0, 1, 5'd2);
        step("post_b3",  T_SQ, B_INCR4, S_W, 1, 32'h508, 1, 0, 6'h00, 0, 8'd0, 1, 5'd3);
        step("post_b4",  T_SQ, B_INCR4, S_W, 1, 32'h50C, 1, 0, 6'h00, 0, 8'd0, 0, 5'd4);
        step("post_ext", T_SQ, B_INCR4, S_W, 1, 32'h510, 1, 0, 6'h09, 1, 8'd1, 0, 5'd4);

        // Control change inside an INCR read burst; INCR ends on IDLE without a length error
        step("ctl_clr",  T_IDLE, B_SINGLE, S_W, 1, 32'h0,   1, 1, 6'h00, 0, 8'd0, 0, 5'd4);
        step("ctl_b1",   T_NS,   B_INCR,   S_W, 0, 32'h600, 1, 0, 6'h00, 0, 8'd0, 1, 5'd1);
        step("ctl_bad",  T_SQ,   B_INCR,   S_W, 1, 32'h604, 1, 0, 6'h04, 1, 8'd1, 1, 5'd2);
        step("ctl_b3",   T_SQ,   B_INCR,   S_W, 0, 32'h608, 1, 0, 6'h04, 0, 8'd1, 1, 5'd3);
        step("ctl_end",  T_IDLE, B_INCR,   S_W, 0, 32'h0,   1, 0, 6'h04, 0, 8'd1, 0, 5'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_protocol_monitor.md
Name: ahb_protocol_monitor

Overview:
- Synthesizable, parametrised AHB-Lite protocol monitor for the ahb_ram environment. Successor to the simulation-only property checker.
- Passively samples the address/control bus on hclk and tracks burst state, beat count and expected next address. Also tracks hready stall length.
- Raises registered sticky error flags, a per-cycle error pulse and a saturating violation counter. Usable in simulation and in emulation/FPGA builds.

Parameters:
- ADDR_W, 32, haddr width.
- DATA_W, 32, hwdata/hrdata width; max legal hsize = log2(DATA_W/8).
- TIMEOUT_CYC, 16, consecutive hready-low cycles that flag a timeout (>=2).
- CNT_W, 8, width of violation counter (saturating).

Ports:
- hclk  in  1  clock.
- hreset  in  1  asynchronous active-high reset.
- htrans  in  2  transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- hburst  in  3  burst type (000 SINGLE, 001 INCR, 010/011 WRAP4/INCR4, 100/101 WRAP8/INCR8, 110/111 WRAP16/INCR16).
- hsize  in  3  transfer size.
- hwrite  in  1  write/read.
- haddr  in  ADDR_W  address.
- hready  in  1  transfer accepted / data phase complete.
- err_clr  in  1  clears sticky flags and counter.
- err_flags  out  6  sticky: [0] seq, [1] addr, [2] ctrl, [3] len, [4] timeout, [5] size/align.
- err_pulse  out  1  high one cycle when any check fires.
- err_count  out  CNT_W  saturating count of cycles with >=1 new violation.
- in_burst  out  1  high while a burst is in progress (FSM in BURST).
- beat_cnt  out  5  beats accepted in current burst.

Behaviour:
- Reset: all outputs 0, FSM = IDLE, expected address = 0, timeout counter = 0.
- Address phase is accepted when hready=1 and htrans is NONSEQ or SEQ. Control is sampled only when hready=1.
- All checks are evaluated on the sampling edge. Flags, pulse and count update one cycle later (registered, latency 1).
- FSM, IDLE state:
  - NONSEQ accepted: latch hburst, hsize, hwrite; beat_cnt=1; compute next address.
  - Go to BURST unless hburst=SINGLE or the fixed length is 1.
  - SEQ or BUSY seen with hready=1: seq error.
- FSM, BURST state:
  - SEQ accepted: beat_cnt+1. Check haddr==expected, else addr error. Check hsize/hburst/hwrite == latched, else ctrl error.
  - BUSY: no advance, no address check.
  - NONSEQ or IDLE before a fixed-length burst completes: len error. NONSEQ restarts tracking (as from IDLE); IDLE returns to IDLE.
  - Fixed length reached (4/8/16): return to IDLE. Any further SEQ is a seq error and a len error.
  - INCR (undefined length): no len check; ends on NONSEQ/IDLE.
- Next address: inc = 1<<hsize.
  - INCR*: addr+inc, modulo 2^ADDR_W.
  - WRAPn: boundary B = n*inc; next = (addr & ~(B-1)) | ((addr+inc) & (B-1)).
- Size/align check on every accepted beat: hsize > log2(DATA_W/8), or haddr not aligned to inc.
- Timeout: count consecutive hready=0 cycles. When the count reaches TIMEOUT_CYC, flag once; the counter holds until hready=1, which resets it to 0.
- err_count: +1 per cycle with any new violation; saturates at all-ones.
- err_clr: clears flags and count. If a violation fires in the same cycle, the new flag is set and count=1.
- Reset mid-burst: immediate return to IDLE, all state cleared. The first beat after reset must be NONSEQ.

Optional Feature:
- Macro AHB_MON_STATS_EN.
- Defined: adds outputs wr_bursts and rd_bursts (CNT_W each, saturating). Each counts bursts completed without error, by direction. Both are cleared by hreset and err_clr.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Shared package ahb_mon_pkg holds:
  - htrans_e and hburst_e enums and the err-bit index constants.
  - burst_len() function (hburst to beats, 0 = undefined).
  - is_wrap() function.
- One sub-module: ahb_addr_calc, combinational next-address generator (inputs addr, hsize, hburst).

Test Plan:
- INCR4 word at 0x100, beats 0x100/104/108/10C, hready=1 -> err_flags=0, in_burst falls after beat 4, beat_cnt=4.
- WRAP4 word starting 0x38 -> expected 0x38,0x3C,0x30,0x34. Drive 0x40 as beat 3 -> err_flags[1]=1, err_pulse for 1 cycle, err_count=1.
- SEQ issued from IDLE after reset -> err_flags[0]=1. Then err_clr asserted together with an INCR8 cut short by NONSEQ after 3 beats -> err_flags=6'b001000, err_count=1.
- hready held 0 for 16 cycles -> err_flags[4] set on cycle 16+1 exactly once. hready held 0 for 15 cycles -> no flag.
- hsize=3'b011 with DATA_W=32, or halfword at 0x101 -> err_flags[5]=1. Then 300 errors with CNT_W=8 -> err_count saturates at 255.
- hreset pulsed mid-INCR16 at beat 5 -> all outputs 0. Next NONSEQ starts clean with no len error.
